// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch prefetch queue.
//   IMEM_WORDS_DEF : default instruction memory size in 32-bit words
//   INSTR_W        : instruction word width
//   state_t        : fetch control state (IDLE / RUN / HALT)
//   fetch_entry_t  : one queued instruction together with its byte address
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int unsigned IMEM_WORDS_DEF = 256;
    localparam int unsigned INSTR_W        = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // Saturating 32-bit add for event counters.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue_if
// Instruction-memory request/response bus between the fetch unit and IMEM.
//   imem_req_o    : fetch request (fetch side drives)
//   imem_addr_o   : word-aligned fetch byte address
//   imem_gnt_i    : memory accepts the request this cycle
//   imem_rvalid_i : response valid, responses return in request order
//   imem_rdata_i  : instruction word
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_prefetch_queue_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

endinterface

// File: rtl/if_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo
// Synchronous in-order FIFO of fetch_entry_t. Flush wins over push and pop.
//   clk_i, rst_i  : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to write
//   pop_i         : drop the head entry
//   flush_i       : empty the FIFO
//   head_o        : current head entry (registered storage)
//   empty_o       : FIFO holds no entries
//   count_o       : number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module if_fifo
    import if_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && !flush_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // NOTE: the storage array is reset along with the pointers so the head
    // outputs read as zero while in reset; it is only DEPTH entries deep.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
// Instruction-fetch front end: issues sequential word-aligned fetches into
// the instruction memory, keeps up to DEPTH instructions in flight or
// buffered, and hands them to decode through a valid/ready handshake.
// A branch redirect flushes the queue and discards stale in-flight responses.
//   clk_i, rst_i    : clock, asynchronous active-low reset
//   imem            : IMEM request/response bus (master modport)
//   redirect_i      : branch taken, restart fetch at redirect_pc_i
//   redirect_pc_i   : redirect target byte address (low bits ignored)
//   instr_valid_o   : queue head valid
//   instr_o         : queue head instruction
//   instr_pc_o      : byte address of the queue head
//   instr_ready_i   : consumer pops the head when valid and ready
//   halted_o        : fetch PC is out of range, no further requests
// Optional (macro IF_PREFETCH_PERF_EN): perf_fetched_o, perf_dropped_o,
// perf_stall_o saturating event counters.
// ---------------------------------------------------------------------------
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    if_prefetch_queue_if.master imem,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        instr_pc_o,
    input  logic               instr_ready_i,
    output logic               halted_o
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_dropped_o,
    output logic [31:0]        perf_stall_o
`endif
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W    = CNT_W + 1;
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

    state_t           state_q;
    state_t           state_d;
    logic [32:0]      fetch_pc_q;   // bit 32 records a wrap past 2^32 as out of range
    logic [31:0]      resp_pc_q;    // PC owed to the next non-stale response
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;
    logic [CNT_W-1:0] stale_q;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             pc_in_range;
    logic             has_room;
    logic             req;
    logic             gnt_acc;
    logic             rsp_drop;
    logic             push;
    logic             pop;

    assign pc_in_range = (fetch_pc_q < PC_LIMIT);
    // Buffered plus in-flight never exceeds DEPTH, so the FIFO cannot overflow.
    assign has_room    = ({1'b0, fifo_count} + {1'b0, inflight_q}) < SUM_W'(DEPTH);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (!pc_in_range) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (redirect_i) state_d = RUN;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req      = 1'b0;
        halted_o = 1'b0;
        case (state_q)
            RUN:     req = pc_in_range && has_room;
            HALT:    halted_o = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Request / response accounting ----------------
    assign gnt_acc    = req && imem.imem_gnt_i;
    // A response in the redirect cycle belongs to the old path as well.
    assign rsp_drop   = imem.imem_rvalid_i && (redirect_i || (stale_q != '0));
    assign push       = imem.imem_rvalid_i && !rsp_drop;
    assign pop        = instr_valid_o && instr_ready_i && !redirect_i;
    assign inflight_d = inflight_q + CNT_W'(gnt_acc) - CNT_W'(imem.imem_rvalid_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= {1'b0, RESET_PC};
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            stale_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (redirect_i) begin
                // Everything still outstanding, including a grant this cycle,
                // will come back on the old path and must be discarded.
                stale_q    <= inflight_d;
                fetch_pc_q <= {1'b0, align_pc(redirect_pc_i)};
                resp_pc_q  <= align_pc(redirect_pc_i);
            end else begin
                if (imem.imem_rvalid_i && (stale_q != '0)) stale_q <= stale_q - CNT_W'(1);
                if (gnt_acc) fetch_pc_q <= fetch_pc_q + 33'd4;
                if (push)    resp_pc_q  <= resp_pc_q + 32'd4;
            end
        end
    end

    assign push_entry = '{pc: resp_pc_q, instr: imem.imem_rdata_i};

    if_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = req ? fetch_pc_q[31:0] : 32'h0;
    assign instr_valid_o    = !fifo_empty;
    assign instr_o          = head.instr;
    assign instr_pc_o       = head.pc;

`ifdef IF_PREFETCH_PERF_EN
    // ---------------- Performance counters ----------------
    logic [31:0] drop_inc;
    assign drop_inc = 32'(rsp_drop) + (redirect_i ? 32'(fifo_count) : 32'd0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetched_o <= '0;
            perf_dropped_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            perf_fetched_o <= sat_add(perf_fetched_o, 32'(push));
            perf_dropped_o <= sat_add(perf_dropped_o, drop_inc);
            perf_stall_o   <= sat_add(perf_stall_o, 32'((state_q == RUN) && !instr_valid_o));
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_queue
// Self-checking bench for if_prefetch_queue. Contains an in-order
// instruction memory (word at byte address A is A>>2) and a reference model
// that tracks the program stream by fetch epoch: a redirect opens a new
// epoch, responses from older epochs never reach the consumer.
// ---------------------------------------------------------------------------
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [32:0] LIMIT = 33'h400;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;

    if_prefetch_queue_if bus();

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    if_prefetch_queue #(.DEPTH(DEPTH), .IMEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem          (bus),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (ready),
        .halted_o      (halted)
`ifdef IF_PREFETCH_PERF_EN
        ,
        .perf_fetched_o(perf_fetched),
        .perf_dropped_o(perf_dropped),
        .perf_stall_o  (perf_stall)
`endif
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    mreq_t       mem_q[$];     // requests accepted by memory, in order
    ent_t        mq[$];        // words the consumer should see, in order
    logic [31:0] grants_q[$];
    logic [31:0] pops_q[$];
    int          cyc;
    int          epoch;
    logic [32:0] exp_fetch;
    bit          started_m;
    bit          halted_m;
    bit          gnt_en, gnt_rand, lat_rand, hold_resp;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        obs_req, obs_valid, obs_halted, obs_rvalid;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        mem_q.delete();
        mq.delete();
        epoch     = 0;
        exp_fetch = 33'h0;
        started_m = 1'b0;
        halted_m  = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        model_clear();
        gnt_en = 1'b1; gnt_rand = 1'b0; lat_rand = 1'b0; hold_resp = 1'b0;
        grants_q.delete(); pops_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
    endtask

    // One clock cycle: drive at negedge, sample and check 1 time unit later,
    // advance the model, then wait for the active edge.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic  in_range;
        logic  exp_req;
        ent_t  e;
        mreq_t r;
        @(negedge clk);
        ready = rdy; redirect = redir; redirect_pc = rpc;
        bus.imem_gnt_i = gnt_en && (gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && !hold_resp &&
            (!lat_rand || $urandom_range(0, 2) != 0)) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = imem_word(mem_q[0].addr);
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = $urandom;
        end
        #1;
        obs_req = bus.imem_req_o; obs_addr = bus.imem_addr_o; obs_rvalid = bus.imem_rvalid_i;
        obs_valid = instr_valid; obs_pc = instr_pc; obs_instr = instr; obs_halted = halted;

        in_range = (exp_fetch < LIMIT);
        exp_req  = started_m && in_range && ((mq.size() + mem_q.size()) < DEPTH);
        check("instr_valid", 32'(obs_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("instr_pc", obs_pc, mq[0].pc);
            check("instr", obs_instr, mq[0].instr);
        end
        check("imem_req", 32'(obs_req), 32'(exp_req));
        if (exp_req) check("imem_addr", obs_addr, exp_fetch[31:0]);
        check("halted", 32'(obs_halted), 32'(halted_m));

        if (mq.size() != 0 && rdy && !redir) void'(mq.pop_front());
        if (obs_valid && rdy && !redir) pops_q.push_back(obs_pc);
        if (obs_rvalid) begin
            r = mem_q.pop_front();
            if (r.epoch == epoch && !redir) begin
                e.pc = r.addr; e.instr = imem_word(r.addr);
                mq.push_back(e);
            end
        end
        if (obs_req && bus.imem_gnt_i) begin
            r.addr = obs_addr; r.epoch = epoch; r.due = cyc + 1;
            mem_q.push_back(r);
            grants_q.push_back(obs_addr);
            exp_fetch = exp_fetch + 33'd4;
        end
        if (redir) begin
            epoch++;
            mq.delete();
            exp_fetch = {1'b0, rpc[31:2], 2'b00};
        end
        halted_m  = redir ? 1'b0 : (halted_m || (started_m && !in_range));
        started_m = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t tbl[7];

    initial begin
        cyc = 0;
        tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h1};
        tbl[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h2};
        tbl[6] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h3};

        // Reset state
        rst_i = 1'b0;
        #1;
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_req", 32'(bus.imem_req_o), 0);
        check("rst_halted", 32'(halted), 0);

        // First-instruction latency and back-to-back streaming
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].ready, 1'b0, 32'h0);
            check("tbl_req", 32'(obs_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) check("tbl_addr", obs_addr, tbl[i].exp_addr);
            check("tbl_valid", 32'(obs_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check("tbl_pc", obs_pc, tbl[i].exp_pc);
                check("tbl_instr", obs_instr, tbl[i].exp_instr);
            end
        end

        // Back-pressure: exactly DEPTH requests, then in-order drain
        do_reset();
        repeat (10) step(1'b0, 1'b0, 32'h0);
        check("bp_grants", grants_q.size(), DEPTH);
        check("bp_req_low", 32'(obs_req), 0);
        for (int i = 0; i < 20 && pops_q.size() < 4; i++) step(1'b1, 1'b0, 32'h0);
        check("bp_pops", pops_q.size(), 4);
        for (int i = 0; i < 4 && i < pops_q.size(); i++) check("bp_pop_pc", pops_q[i], 32'(4 * i));
        check("bp_resume_seen", 32'(grants_q.size() > 4), 1);
        if (grants_q.size() > 4) check("bp_resume_addr", grants_q[4], 32'h10);

        // Redirect with two requests in flight and one word queued
        do_reset();
        step(1'b0, 1'b1, 32'h10);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        hold_resp = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        check("rd_queued_pc", obs_pc, 32'h10);
        gnt_en = 1'b0;
        step(1'b1, 1'b1, 32'h41);
        step(1'b1, 1'b0, 32'h0);
        check("rd_flushed", 32'(obs_valid), 0);
        hold_resp = 1'b0; gnt_en = 1'b1;
        for (int i = 0; i < 40 && pops_q.size() == 0; i++) step(1'b1, 1'b0, 32'h0);
        check("rd_pop_seen", 32'(pops_q.size() != 0), 1);
        if (pops_q.size() != 0) check("rd_first_pc", pops_q[0], 32'h40);

        // Redirect coinciding with a grant and a response
        do_reset();
        repeat (5) step(1'b1, 1'b0, 32'h0);
        pops_q.delete();
        step(1'b1, 1'b1, 32'h100);
        check("rg_same_cycle", 32'(obs_req && bus.imem_gnt_i && obs_rvalid), 1);
        for (int i = 0; i < 40 && pops_q.size() == 0; i++) step(1'b1, 1'b0, 32'h0);
        check("rg_pop_seen", 32'(pops_q.size() != 0), 1);
        if (pops_q.size() != 0) check("rg_first_pc", pops_q[0], 32'h100);

        // Running off the end of memory, then redirect back
        do_reset();
        step(1'b1, 1'b1, 32'h3F0);
        repeat (15) step(1'b1, 1'b0, 32'h0);
        check("end_pops", pops_q.size(), 4);
        if (pops_q.size() == 4) check("end_last_pc", pops_q[3], 32'h3FC);
        check("end_grants", grants_q.size(), 4);
        check("end_halted", 32'(obs_halted), 1);
        check("end_req_low", 32'(obs_req), 0);
        pops_q.delete();
        step(1'b1, 1'b1, 32'h8);
        for (int i = 0; i < 40 && pops_q.size() == 0; i++) step(1'b1, 1'b0, 32'h0);
        check("end_pop_seen", 32'(pops_q.size() != 0), 1);
        if (pops_q.size() != 0) check("end_restart_pc", pops_q[0], 32'h8);
        check("end_unhalted", 32'(obs_halted), 0);

        // Asynchronous reset with three entries queued
        do_reset();
        repeat (5) step(1'b0, 1'b0, 32'h0);
        check("ar_queued", 32'(instr_valid), 1);
        #2 rst_i = 1'b0;
        #1;
        check("ar_valid", 32'(instr_valid), 0);
        check("ar_instr", instr, 0);
        check("ar_pc", instr_pc, 0);
        check("ar_req", 32'(bus.imem_req_o), 0);
        check("ar_addr", bus.imem_addr_o, 0);
        check("ar_halted", 32'(halted), 0);
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("ar_restart_req", 32'(obs_req), 1);
        check("ar_restart_addr", obs_addr, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        gnt_rand = 1'b1; lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic        rdy, rd;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 7))
                0:       tgt = 32'h3E0 + $urandom_range(0, 31);
                1:       tgt = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC : 32'h400 + $urandom_range(0, 255);
                default: tgt = $urandom_range(0, 32'h3FF);
            endcase
            step(rdy, rd, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the MIPS execute/decode stage.
- Generates sequential word-aligned fetch addresses into the 256-word instruction memory and keeps up to DEPTH requests in flight.
- Buffers returned words in a small in-order queue and presents them to the consumer with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries and maximum in-flight plus buffered instructions (power of 2, ≥2).
- IMEM_WORDS, 256, instruction memory size in words; byte addresses at or above IMEM_WORDS*4 are out of range.
- RESET_PC, 32'h0, first fetch byte address after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset (asynchronous, active-low).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch byte address, bits [1:0] always 0.
- imem_gnt_i  in  1  memory accepts the request this cycle.
- imem_rvalid_i  in  1  response data valid; responses return in order.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  branch taken; restart fetch at the new PC.
- redirect_pc_i  in  32  redirect target byte address.
- instr_valid_o  out  1  queue head valid.
- instr_o  out  32  queue head instruction.
- instr_pc_o  out  32  byte address of the queue head.
- instr_ready_i  in  1  consumer pops the head when valid and ready are both high.
- halted_o  out  1  fetch PC is out of range; no further requests are issued.

Behaviour:
- Reset, asynchronous (rst_i=0): all outputs 0, queue empty, in-flight count 0, stale count 0, fetch PC = RESET_PC, state = IDLE.
- State IDLE: held for exactly 1 cycle after rst_i deasserts, then moves to RUN.
- State RUN issue rule:
  - imem_req_o=1 when queue occupancy + in-flight < DEPTH and fetch PC < IMEM_WORDS*4.
  - imem_req_o is held with a stable address until imem_gnt_i.
  - On gnt: in-flight increments and fetch PC advances by 4.
- RUN → HALT when fetch PC ≥ IMEM_WORDS*4. In HALT: imem_req_o=0, halted_o=1. Already-queued words still drain.
- HALT → RUN only on redirect_i.
- Response handling:
  - On rvalid: in-flight decrements.
  - If stale count > 0, the word is dropped and stale count decrements.
  - Otherwise the word is written to the queue tail together with its PC; a per-entry PC tag follows request order.
- Output timing:
  - instr_valid_o, instr_o and instr_pc_o are driven from registered queue storage, with no rvalid bypass.
  - A word returned in cycle N is visible at the head in cycle N+1.
- Minimum latency, first instruction: req+gnt in cycle 1 after IDLE, rvalid in cycle 2, instr_valid_o in cycle 3.
- Push and pop may occur in the same cycle; occupancy is then unchanged. Full queue never overflows, by construction of the issue rule.
- Redirect (highest priority, takes effect the same cycle):
  - Queue cleared; any pop in that cycle is ignored.
  - stale count := in-flight after this cycle's gnt and rvalid updates, so a request granted in the redirect cycle counts as stale.
  - An rvalid word arriving in the redirect cycle is dropped.
  - Fetch PC := {redirect_pc_i[31:2], 2'b00}; state := RUN.
  - instr_valid_o=0 in the following cycle.
- Redirect to an out-of-range PC: goes to RUN for 1 cycle, then to HALT, and no request is issued.
- Address arithmetic is 32-bit unsigned. PC+4 wrapping past 2^32 is out of range by definition (HALT).
- Reset asserted mid-operation: immediate clear. Responses from requests outstanding at reset are the memory model's responsibility and are not accounted for.

Optional Feature:
- Macro IF_PREFETCH_PERF_EN.
- When defined, adds outputs perf_fetched_o[31:0], perf_dropped_o[31:0] and perf_stall_o[31:0]:
  - perf_fetched_o counts queue pushes.
  - perf_dropped_o counts stale drops plus queue entries flushed by redirect.
  - perf_stall_o counts cycles with instr_valid_o=0 while state=RUN.
  - All three reset to 0 and saturate at 2^32-1.
- When undefined: no ports, no logic.

Decomposition:
- Shared package if_pkg:
  - IMEM_WORDS_DEF=256 and INSTR_W=32.
  - State enum {IDLE, RUN, HALT}.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module if_fifo: synchronous FIFO of fetch_entry_t with DEPTH entries, push/pop/flush, count output, flush-over-push priority.

Test Plan:
- Reset release, memory with gnt=1 and 1-cycle rvalid, Instr_Mem[i]=i, ready=1: instr_valid_o first in cycle 3; outputs (pc,instr)=(0,0),(4,1),(8,2)… back-to-back, one per cycle.
- ready=0 held for 10 cycles: exactly DEPTH=4 requests issued, imem_req_o then 0. After ready=1: PCs 0,4,8,12 delivered in order and fetching resumes at 16.
- 2 requests in flight and queue holding PC 0x10, redirect_pc_i=0x41: queue empties; the next 2 rvalids are dropped; next delivered entry has pc=0x40.
- Redirect in the same cycle as gnt and rvalid: both responses, current and granted, dropped (perf_dropped_o +2 with the macro defined); no stale word ever reaches instr_o.
- Sequential fetch reaching PC 0x3FC: entry 0x3FC delivered, then halted_o=1 and imem_req_o stays 0. redirect_pc_i=0x8 returns to RUN and delivers pc=0x8.
- rst_i pulsed low mid-stream with 3 entries queued: all outputs 0 asynchronously; after release, fetch restarts at RESET_PC=0.
